// File: rtl/ps_pcstck.sv
// ps_pcstck: return-PC stack with one-cycle delayed push/pop, ureg overwrite of the top and sticky flags.
// Optional macro PS_PCSTCK_BYPASS_EN forwards ps_wrt_dt onto ps_top in the cycle of the write.
module ps_pcstck #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps_push,
    input  logic          ps_pop,
    input  logic [AW-1:0] ps_push_dt,
    input  logic          ps_wrt_en,
    input  logic [AW-1:0] ps_wrt_dt,
    input  logic          ps_clr_stcky,
    output logic [AW-1:0] ps_top,
    output logic [PW-1:0] ps_pntr,
    output logic [3:0]    ps_stcky
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [AW-1:0] entries [DEPTH];
    logic [PW-1:0] count;
    logic          push_d;
    logic          pop_d;
    logic [AW-1:0] data_d;
    logic          ovf;
    logic          unf;

    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_repl;
    logic          do_pop;
    logic          do_wrt;
    logic          set_ovf;
    logic          set_unf;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    // Push+pop on a non-empty stack is a top replace; on an empty stack it degrades to a push.
    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL);
        wr_idx  = IW'(count);
        top_idx = IW'(count - ONE);
        do_push = push_d && (!pop_d || empty) && !full;
        set_ovf = push_d && !pop_d && full;
        do_repl = push_d && pop_d && !empty;
        do_pop  = pop_d && !push_d && !empty;
        set_unf = pop_d && !push_d && empty;
        do_wrt  = ps_wrt_en && !empty && !push_d && !pop_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_d <= 1'b0;
            pop_d  <= 1'b0;
            data_d <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[IW'(i)] <= '0;
            end
        end else begin
            push_d <= ps_push;
            pop_d  <= ps_pop;
            data_d <= ps_push_dt;
            if (do_push) begin
                entries[wr_idx] <= data_d;
                count           <= count + ONE;
            end else if (do_repl) begin
                entries[top_idx] <= data_d;
            end else if (do_pop) begin
                count <= count - ONE;
            end else if (do_wrt) begin
                entries[top_idx] <= ps_wrt_dt;
            end
            ovf <= set_ovf | (ovf & ~ps_clr_stcky);
            unf <= set_unf | (unf & ~ps_clr_stcky);
        end
    end

    always_comb begin
        ps_top = empty ? '0 : entries[top_idx];
`ifdef PS_PCSTCK_BYPASS_EN
        if (do_wrt) ps_top = ps_wrt_dt;
`endif
    end

    assign ps_pntr  = count;
    assign ps_stcky = {unf, ovf, full, empty};

endmodule

// File: tb/tb_ps_pcstck.sv
// tb_ps_pcstck: scoreboard bench for ps_pcstck (DEPTH=4, AW=16) against a queue-based stack model.
// Directed vectors from the stack's documented examples, then randomized traffic.
module tb_ps_pcstck;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ps_push = 1'b0;
    logic          ps_pop = 1'b0;
    logic [AW-1:0] ps_push_dt = '0;
    logic          ps_wrt_en = 1'b0;
    logic [AW-1:0] ps_wrt_dt = '0;
    logic          ps_clr_stcky = 1'b0;
    logic [AW-1:0] ps_top;
    logic [PW-1:0] ps_pntr;
    logic [3:0]    ps_stcky;

    ps_pcstck #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .ps_push(ps_push), .ps_pop(ps_pop), .ps_push_dt(ps_push_dt),
        .ps_wrt_en(ps_wrt_en), .ps_wrt_dt(ps_wrt_dt), .ps_clr_stcky(ps_clr_stcky),
        .ps_top(ps_top), .ps_pntr(ps_pntr), .ps_stcky(ps_stcky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] top;
        logic [PW-1:0] pntr;
        logic [3:0]    stcky;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a queue is the stack; requests wait one edge before acting.
    logic [AW-1:0] mstk[$];
    logic          m_pend_push, m_pend_pop;
    logic [AW-1:0] m_pend_data;
    logic          m_ovf, m_unf;

    function automatic exp_t model_expect();
        exp_t e;
        e.pntr  = PW'(mstk.size());
        e.top   = (mstk.size() > 0) ? mstk[$] : '0;
`ifdef PS_PCSTCK_BYPASS_EN
        if (ps_wrt_en && mstk.size() > 0 && !m_pend_push && !m_pend_pop) e.top = ps_wrt_dt;
`endif
        e.stcky = {m_unf, m_ovf, mstk.size() == DEPTH, mstk.size() == 0};
        return e;
    endfunction

    task automatic model_reset();
        mstk.delete();
        m_pend_push = 1'b0;
        m_pend_pop  = 1'b0;
        m_pend_data = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge();
        bit sov = 0, sun = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_pend_push && (!m_pend_pop || mstk.size() == 0)) begin
            if (mstk.size() < DEPTH) mstk.push_back(m_pend_data);
            else sov = 1;
        end else if (m_pend_push && m_pend_pop) begin
            mstk[mstk.size() - 1] = m_pend_data;
        end else if (m_pend_pop) begin
            if (mstk.size() > 0) void'(mstk.pop_back());
            else sun = 1;
        end else if (ps_wrt_en && mstk.size() > 0) begin
            mstk[mstk.size() - 1] = ps_wrt_dt;
        end
        m_ovf = sov ? 1'b1 : (ps_clr_stcky ? 1'b0 : m_ovf);
        m_unf = sun ? 1'b1 : (ps_clr_stcky ? 1'b0 : m_unf);
        m_pend_push = ps_push;
        m_pend_pop  = ps_pop;
        m_pend_data = ps_push_dt;
    endtask

    // Monitor: the DUT presents a new state every cycle; compare it on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (ps_pntr !== e.pntr || ps_top !== e.top || ps_stcky !== e.stcky) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t: pntr=%0d top=%h stcky=%b, expected pntr=%0d top=%h stcky=%b",
                         $time, ps_pntr, ps_top, ps_stcky, e.pntr, e.top, e.stcky);
            end
        end
    end

    // Each step starts just after a falling edge and ends just after the next one.
    task automatic step(input logic push, input logic pop, input logic [AW-1:0] data,
                        input logic wen, input logic [AW-1:0] wdt, input logic clr);
        ps_push = push; ps_pop = pop; ps_push_dt = data;
        ps_wrt_en = wen; ps_wrt_dt = wdt; ps_clr_stcky = clr;
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_expect());
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [AW-1:0] d);
        step(1'b1, 1'b0, d, 1'b0, '0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [PW-1:0] p, input logic [AW-1:0] t, input logic [3:0] s);
        vectors++;
        if (ps_pntr !== p || ps_top !== t || ps_stcky !== s) begin
            miscompares++;
            $display("FAIL %s: pntr=%0d top=%h stcky=%b, expected pntr=%0d top=%h stcky=%b",
                     name, ps_pntr, ps_top, ps_stcky, p, t, s);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ps_push = 1'b0; ps_pop = 1'b0; ps_wrt_en = 1'b0; ps_clr_stcky = 1'b0;
        model_reset();
        #1;
        chk("reset_async", 3'd0, 16'h0000, 4'b0001);
        idle();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk); #1;
        do_reset();

        push(16'h0010); push(16'h0020); push(16'h0030); idle();
        chk("push3", 3'd3, 16'h0030, 4'b0000);

        do_reset();
        for (int i = 0; i < 5; i++) push(AW'(16'hA000 + i));
        idle();
        chk("overflow", 3'd4, 16'hA003, 4'b0110);
        idle(); idle();
        chk("overflow_hold", 3'd4, 16'hA003, 4'b0110);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("overflow_clear", 3'd4, 16'hA003, 4'b0010);

        do_reset();
        step(1'b0, 1'b1, '0, 1'b0, '0, 1'b0); idle();
        chk("underflow", 3'd0, 16'h0000, 4'b1001);
        push(16'h0042); idle();
        chk("push_after_uf", 3'd1, 16'h0042, 4'b1000);

        do_reset();
        push(16'h0010); push(16'h0020); idle();
        chk("two_entries", 3'd2, 16'h0020, 4'b0000);
        step(1'b1, 1'b1, 16'h0055, 1'b0, '0, 1'b0); idle();
        chk("push_pop_replace", 3'd2, 16'h0055, 4'b0000);
        do_reset();
        step(1'b1, 1'b1, 16'h0055, 1'b0, '0, 1'b0); idle();
        chk("push_pop_empty", 3'd1, 16'h0055, 4'b0000);

        do_reset();
        push(16'h0011); idle();
        step(1'b0, 1'b0, '0, 1'b1, 16'hBEEF, 1'b0);
        chk("ureg_write", 3'd1, 16'hBEEF, 4'b0000);
        step(1'b0, 1'b1, '0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 16'hBEEF, 1'b0);
        chk("ureg_vs_pop", 3'd0, 16'h0000, 4'b0001);

        do_reset();
        push(16'h0010); idle();
        push(16'h0077);
        rst = 1'b0;
        model_reset();
        #1;
        chk("reset_pending", 3'd0, 16'h0000, 4'b0001);
        idle();
        rst = 1'b1;
        idle(); idle();
        chk("pending_lost", 3'd0, 16'h0000, 4'b0001);

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            else step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35, AW'($urandom),
                      $urandom_range(0, 99) < 25, AW'($urandom), $urandom_range(0, 99) < 10);
        end
        idle();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
